// File: rtl/gate_step_sequencer_if.sv
// gate_step_sequencer_if
//   Bundles the program-load port, the run handshake and the two
//   wire-selection stage buses of the gate step sequencer.
//   slave  : the sequencer side (receives program/run requests and the
//            registered a/b/c, drives selects, gate results and status).
//   master : the controller / selection-stage side.
interface gate_step_sequencer_if #(
  parameter int NUMBER_OF_INPUT_WIRES = 4,
  parameter int CHOICE_WIDTH          = $clog2(NUMBER_OF_INPUT_WIRES),
  parameter int PROGRAM_DEPTH         = 16,
  parameter int PC_WIDTH              = $clog2(PROGRAM_DEPTH),
  parameter int INSTR_WIDTH           = 2 + 3*CHOICE_WIDTH
);
  // program load
  logic                    prog_we;
  logic [PC_WIDTH-1:0]     prog_addr;
  logic [INSTR_WIDTH-1:0]  prog_data;
  // run handshake
  logic                    start;
  logic [PC_WIDTH:0]       prog_length;
  logic                    busy;
  logic                    done;
  logic [PC_WIDTH-1:0]     pc;
  // input-selection stage
  logic [CHOICE_WIDTH-1:0] in_a_select, in_b_select, in_c_select;
  logic                    a_in, b_in, c_in;
  // output-selection stage
  logic [CHOICE_WIDTH-1:0] out_a_select, out_b_select, out_c_select;
  logic                    out_a, out_b, out_c;

  modport slave (
    input  prog_we, prog_addr, prog_data, start, prog_length,
    input  a_in, b_in, c_in,
    output in_a_select, in_b_select, in_c_select,
    output out_a_select, out_b_select, out_c_select,
    output out_a, out_b, out_c, busy, done, pc
  );

  modport master (
    output prog_we, prog_addr, prog_data, start, prog_length,
    output a_in, b_in, c_in,
    input  in_a_select, in_b_select, in_c_select,
    input  out_a_select, out_b_select, out_c_select,
    input  out_a, out_b, out_c, busy, done, pc
  );
endinterface

// File: rtl/gate_step_sequencer.sv
// gate_step_sequencer
//   Steps through a loadable program of reversible gates, one gate every
//   3 cycles (ISSUE -> EXEC -> COMMIT). ISSUE drives the input-selection
//   stage selects, EXEC computes the gate from the registered a/b/c and
//   registers result + selects toward the output-selection stage, COMMIT
//   lets the output stage capture them and advances the pc.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   bus (slave)       program write, start/prog_length, busy/done/pc,
//                     in_*_select / a_in,b_in,c_in, out_*_select / out_*
//   single_step, step only with GATE_STEP_SEQUENCER_SINGLE_STEP_EN:
//                     pause after each non-final gate until step
// Optional feature macro: GATE_STEP_SEQUENCER_SINGLE_STEP_EN
// Instruction word: {op[1:0], a_sel, b_sel, c_sel}
//   op 00 NOP, 01 NOT (c^=1), 10 CNOT (c^=b), 11 CCNOT (c^=a&b)
module gate_step_sequencer #(
  parameter int NUMBER_OF_INPUT_WIRES = 4,
  parameter int CHOICE_WIDTH          = $clog2(NUMBER_OF_INPUT_WIRES),
  parameter int PROGRAM_DEPTH         = 16,
  parameter int PC_WIDTH              = $clog2(PROGRAM_DEPTH),
  parameter int INSTR_WIDTH           = 2 + 3*CHOICE_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef GATE_STEP_SEQUENCER_SINGLE_STEP_EN
  input  logic                   single_step,
  input  logic                   step,
`endif
  gate_step_sequencer_if.slave   bus
);

`ifdef GATE_STEP_SEQUENCER_SINGLE_STEP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_EXEC, S_COMMIT, S_FINISH, S_PAUSE
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_EXEC, S_COMMIT, S_FINISH
  } state_t;
`endif

  localparam logic [PC_WIDTH:0] DEPTH_L = (PC_WIDTH+1)'(PROGRAM_DEPTH);

  state_t                            state_q, state_d;
  logic [PC_WIDTH-1:0]               pc_q, pc_d;
  logic [PC_WIDTH-1:0]               last_q, last_d;   // index of final gate
  logic [2:0][CHOICE_WIDTH-1:0]      in_sel_q, in_sel_d;  // [2]=a [1]=b [0]=c
  logic [2:0][CHOICE_WIDTH-1:0]      out_sel_q, out_sel_d;
  logic [2:0]                        out_val_q, out_val_d;

  logic [INSTR_WIDTH-1:0]            mem [PROGRAM_DEPTH];
  logic [INSTR_WIDTH-1:0]            instr;
  logic [1:0]                        op;
  logic [2:0][CHOICE_WIDTH-1:0]      instr_sel;
  logic                              c_res;
  logic [PC_WIDTH:0]                 len_clamped;

  assign instr     = mem[pc_q];
  assign op        = instr[INSTR_WIDTH-1 -: 2];
  assign instr_sel = instr[3*CHOICE_WIDTH-1:0];
  assign len_clamped = (bus.prog_length > DEPTH_L) ? DEPTH_L : bus.prog_length;

  // Program memory is deliberately not reset; writes only land in IDLE.
  always_ff @(posedge clk) begin
    if (bus.prog_we && state_q == S_IDLE)
      mem[bus.prog_addr] <= bus.prog_data;
  end

  // a and b pass through; only c is modified.
  always_comb begin
    c_res = bus.c_in;
    case (op)
      2'b00:   c_res = bus.c_in;
      2'b01:   c_res = ~bus.c_in;
      2'b10:   c_res = bus.c_in ^ bus.b_in;
      default: c_res = bus.c_in ^ (bus.a_in & bus.b_in);
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      last_q    <= '0;
      in_sel_q  <= '0;
      out_sel_q <= '0;
      out_val_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      last_q    <= last_d;
      in_sel_q  <= in_sel_d;
      out_sel_q <= out_sel_d;
      out_val_q <= out_val_d;
    end
  end

  // next state
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    last_d    = last_q;
    in_sel_d  = in_sel_q;
    out_sel_d = out_sel_q;
    out_val_d = out_val_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.prog_length == '0) begin
            state_d = S_FINISH;
          end else begin
            last_d  = PC_WIDTH'(len_clamped - 1'b1);
            pc_d    = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        in_sel_d = instr_sel;   // hold what was issued once ISSUE ends
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        out_val_d = {bus.a_in, bus.b_in, c_res};
        out_sel_d = instr_sel;
        state_d   = S_COMMIT;
      end
      S_COMMIT: begin
        if (pc_q == last_q) begin
          state_d = S_FINISH;
        end else begin
`ifdef GATE_STEP_SEQUENCER_SINGLE_STEP_EN
          if (single_step) begin
            state_d = S_PAUSE;
          end else begin
            pc_d    = pc_q + PC_WIDTH'(1);
            state_d = S_ISSUE;
          end
`else
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = S_ISSUE;
`endif
        end
      end
`ifdef GATE_STEP_SEQUENCER_SINGLE_STEP_EN
      S_PAUSE: begin
        // leaving single-step mode also releases the pause
        if (step || !single_step) begin
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = S_ISSUE;
        end
      end
`endif
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    bus.busy = (state_q != S_IDLE);
    bus.done = (state_q == S_FINISH);
    bus.pc   = pc_q;
    if (state_q == S_ISSUE) begin
      bus.in_a_select = instr_sel[2];
      bus.in_b_select = instr_sel[1];
      bus.in_c_select = instr_sel[0];
    end else begin
      bus.in_a_select = in_sel_q[2];
      bus.in_b_select = in_sel_q[1];
      bus.in_c_select = in_sel_q[0];
    end
    bus.out_a_select = out_sel_q[2];
    bus.out_b_select = out_sel_q[1];
    bus.out_c_select = out_sel_q[0];
    bus.out_a        = out_val_q[2];
    bus.out_b        = out_val_q[1];
    bus.out_c        = out_val_q[0];
  end

endmodule

// File: tb/tb_gate_step_sequencer.sv
// tb_gate_step_sequencer
//   Scoreboard bench: each run is turned into a per-cycle list of expected
//   bus snapshots from the sequencing rules (3 cycles per gate, done one
//   cycle after the last commit), pushed to a queue, and a negedge monitor
//   pops and compares. a/b/c returned in each gate's EXEC cycle are chosen
//   up front so the gate result is known; all other cycles carry noise.
module tb_gate_step_sequencer;
  localparam int NW  = 4;
  localparam int CW  = 2;
  localparam int PD  = 16;
  localparam int PCW = 4;
  localparam int IW  = 2 + 3*CW;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
`ifdef GATE_STEP_SEQUENCER_SINGLE_STEP_EN
  logic single_step, step;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_step_sequencer_if #(.NUMBER_OF_INPUT_WIRES(NW), .CHOICE_WIDTH(CW),
    .PROGRAM_DEPTH(PD), .PC_WIDTH(PCW), .INSTR_WIDTH(IW)) bus ();

  gate_step_sequencer #(.NUMBER_OF_INPUT_WIRES(NW), .CHOICE_WIDTH(CW),
    .PROGRAM_DEPTH(PD), .PC_WIDTH(PCW), .INSTR_WIDTH(IW)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef GATE_STEP_SEQUENCER_SINGLE_STEP_EN
    .single_step (single_step),
    .step        (step),
`endif
    .bus         (bus)
  );

  typedef struct {
    int                  cyc;
    logic [2:0][CW-1:0]  in_sel;
    logic [2:0]          outv;
    logic [2:0][CW-1:0]  out_sel;
    logic [PCW-1:0]      pc;
    logic                busy;
    logic                done;
  } exp_t;

  exp_t               sb[$];
  logic [IW-1:0]      m_mem [PD];
  logic [2:0][CW-1:0] m_in_sel, m_out_sel;
  logic [2:0]         m_outv;
  logic [PCW-1:0]     m_pc;
  logic [2:0]         abc_plan [PD];   // {a,b,c} returned for gate k

  function automatic void push(input int c, input logic b, input logic d);
    exp_t e;
    e.cyc = c; e.in_sel = m_in_sel; e.outv = m_outv; e.out_sel = m_out_sel;
    e.pc = m_pc; e.busy = b; e.done = d;
    sb.push_back(e);
  endfunction

  task automatic chk(input string nm, input int c, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, c, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("missed_sample", e.cyc, 32'(cyc), 32'(e.cyc));
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      chk("in_sel",  cyc, {bus.in_a_select, bus.in_b_select, bus.in_c_select}, e.in_sel);
      chk("out_val", cyc, {bus.out_a, bus.out_b, bus.out_c}, e.outv);
      chk("out_sel", cyc, {bus.out_a_select, bus.out_b_select, bus.out_c_select}, e.out_sel);
      chk("pc",      cyc, bus.pc, e.pc);
      chk("busy",    cyc, bus.busy, e.busy);
      chk("done",    cyc, bus.done, e.done);
    end else if (bus.done === 1'b1) begin
      chk("spurious_done", cyc, bus.done, 0);
    end
  end

  task automatic step_clk();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      push(cyc, 1'b0, 1'b0);
      step_clk();
    end
  endtask

  task automatic write_instr(input int addr, input logic [IW-1:0] d);
    bus.prog_we = 1'b1; bus.prog_addr = PCW'(addr); bus.prog_data = d;
    m_mem[addr] = d;
    push(cyc, 1'b0, 1'b0);
    step_clk();
    bus.prog_we = 1'b0;
  endtask

  // len_in: requested length; abort_k: gate whose EXEC gets reset (-1 none);
  // pause: cycles spent paused after gate 0; poke: start/prog_we while busy
  task automatic run(input int len_in, input int abort_k, input int pause,
                     input bit poke);
    int n, s, t, fin, rst_at, step_at;
    int exec_at [PD];
    logic [IW-1:0] ins;
    logic a, b, c, r;
    n = (len_in > PD) ? PD : len_in;
    s = cyc; rst_at = -1; step_at = -1; fin = s + 2;
    for (int k = 0; k < PD; k++) exec_at[k] = -1;
    push(s, 1'b0, 1'b0);
    t = s + 1;
    for (int k = 0; k < n; k++) begin
      ins = m_mem[k];
      m_in_sel = ins[3*CW-1:0];
      m_pc = PCW'(k);
      push(t, 1'b1, 1'b0);
      push(t + 1, 1'b1, 1'b0);
      exec_at[k] = t + 1;
      if (k == abort_k) begin
        rst_at = t + 1;
        m_in_sel = '0; m_outv = '0; m_out_sel = '0; m_pc = '0;
        push(t + 2, 1'b0, 1'b0);
        fin = t + 2;
        break;
      end
      {a, b, c} = abc_plan[k];
      case (ins[IW-1 -: 2])
        2'b00:   r = c;
        2'b01:   r = !c;
        2'b10:   r = c ^ b;
        default: r = c ^ (a & b);
      endcase
      m_outv = {a, b, r};
      m_out_sel = ins[3*CW-1:0];
      push(t + 2, 1'b1, 1'b0);
      t += 3;
      if (k == 0 && pause > 0 && n > 1) begin
        for (int p = 0; p < pause; p++) push(t + p, 1'b1, 1'b0);
        t += pause;
        step_at = t - 1;
      end
    end
    if (rst_at < 0) begin
      push(t, 1'b1, 1'b1);
      push(t + 1, 1'b0, 1'b0);
      fin = t + 1;
    end
    for (int cc = s; cc <= fin; cc++) begin
      bus.start = (cc == s);
      bus.prog_length = (cc == s) ? (PCW+1)'(len_in) : (PCW+1)'($urandom);
      bus.prog_we = 1'b0;
      bus.prog_addr = PCW'($urandom);
      bus.prog_data = IW'($urandom);
      {bus.a_in, bus.b_in, bus.c_in} = 3'($urandom);
      for (int k = 0; k < n; k++)
        if (exec_at[k] == cc) {bus.a_in, bus.b_in, bus.c_in} = abc_plan[k];
      reset = (cc == rst_at);
      if (poke && cc > s && cc < fin) begin
        bus.start = 1'b1;
        bus.prog_we = 1'b1;
      end
`ifdef GATE_STEP_SEQUENCER_SINGLE_STEP_EN
      single_step = (pause > 0) && (cc < fin);
      step = (cc == step_at);
`endif
      step_clk();
    end
    bus.start = 1'b0; bus.prog_we = 1'b0; reset = 1'b0;
`ifdef GATE_STEP_SEQUENCER_SINGLE_STEP_EN
    single_step = 1'b0; step = 1'b0;
`endif
  endtask

  task automatic rand_plan();
    for (int k = 0; k < PD; k++) abc_plan[k] = 3'($urandom);
  endtask

  initial begin
    reset = 1'b1;
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_data = '0;
    bus.start = 1'b0; bus.prog_length = '0;
    bus.a_in = 1'b0; bus.b_in = 1'b0; bus.c_in = 1'b0;
`ifdef GATE_STEP_SEQUENCER_SINGLE_STEP_EN
    single_step = 1'b0; step = 1'b0;
`endif
    m_in_sel = '0; m_out_sel = '0; m_outv = '0; m_pc = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // reset state, idle
    idle(5);
    for (int k = 0; k < PD; k++) write_instr(k, IW'($urandom));

    // single CCNOT, a=1 b=1 c=0 -> c=1
    write_instr(0, {2'b11, 2'd0, 2'd1, 2'd2});
    abc_plan[0] = 3'b110;
    run(1, -1, 0, 1'b0);
    idle(2);

    // NOT, CNOT, CCNOT, NOP
    write_instr(0, {2'b01, 2'd0, 2'd1, 2'd2});
    write_instr(1, {2'b10, 2'd1, 2'd2, 2'd3});
    write_instr(2, {2'b11, 2'd2, 2'd3, 2'd0});
    write_instr(3, {2'b00, 2'd3, 2'd0, 2'd1});
    rand_plan();
    run(4, -1, 0, 1'b0);
    idle(2);

    // zero length, then start/prog_we while busy, then rerun to prove mem intact
    run(0, -1, 0, 1'b0);
    rand_plan();
    run(4, -1, 0, 1'b1);
    run(0, -1, 0, 1'b1);
    rand_plan();
    run(4, -1, 0, 1'b0);

    // reset in EXEC of gate index 1, then full rerun
    rand_plan();
    run(4, 1, 0, 1'b0);
    idle(2);
    rand_plan();
    run(4, -1, 0, 1'b0);

    // clamp
    rand_plan();
    run(20, -1, 0, 1'b0);

    // random programs
    for (int it = 0; it < 20; it++) begin
      int nw;
      nw = int'($urandom_range(0, 4));
      for (int w = 0; w < nw; w++) write_instr(int'($urandom_range(0, PD-1)), IW'($urandom));
      rand_plan();
      run(int'($urandom_range(0, 20)), -1, 0, 1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

`ifdef GATE_STEP_SEQUENCER_SINGLE_STEP_EN
    rand_plan();
    run(2, -1, 7, 1'b0);
    idle(2);
`endif

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
